dual_port_ram: RTL and testbench
================================

Name: dual_port_ram

Overview:
- True dual-port synchronous RAM with two fully independent read/write ports, A and B, sharing one storage array.
- Used as the packet buffer in the USB packet generator. One port is on the packet-assembly side, the other on the transmit side.
- Both ports run on a single clock (nominal 83 ns period, about 12 MHz).

Parameters:
- DATA_WIDTH, 8, width of each word in bits.
- ADDR_WIDTH, 8, address width in bits.
- DEPTH, 2**ADDR_WIDTH (256), number of words. Derived; do not override independently.

Ports:
- clk  input  1  system clock; all activity on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable_port_a  input  1  port A access enable.
- write_port_a  input  1  port A write (1) or read (0); qualified by enable_port_a.
- address_port_a  input  ADDR_WIDTH  port A word address.
- data_in_port_a  input  DATA_WIDTH  port A write data.
- data_out_port_a  output  DATA_WIDTH  port A registered read data.
- enable_port_b  input  1  port B access enable.
- write_port_b  input  1  port B write (1) or read (0); qualified by enable_port_b.
- address_port_b  input  ADDR_WIDTH  port B word address.
- data_in_port_b  input  DATA_WIDTH  port B write data.
- data_out_port_b  output  DATA_WIDTH  port B registered read data.

Behaviour:
- Reset:
  - rst=1 asynchronously forces data_out_port_a and data_out_port_b to 0.
  - Memory contents are not cleared by reset and are undefined after power-up.
  - Writes and reads are ignored while rst=1.
- Write: enable=1, write=1 at a rising edge stores data_in into mem[address] at that edge. The port's data_out holds its previous value.
- Read: enable=1, write=0 at rising edge N loads mem[address] into data_out at edge N. The value is visible after N and stays valid until the next read on that port. Latency is 1 cycle.
- Idle: enable=0 means no memory change and data_out holds its value.
- Port B reads an address that port A writes in the same cycle (and vice versa): read-first. The reader gets the OLD contents; the new data is visible from the next read.
- Both ports write the same address in the same cycle: port A wins, so mem holds data_in_port_a.
- Both ports read the same address in the same cycle: both get identical data.
- Addresses use the full range 0..DEPTH-1 with no wrap or out-of-range case. Addresses are not registered beyond the access cycle.
- No handshake and no back-pressure: every enabled access completes in its cycle.
- Deassertion of reset mid-operation: the first edge with rst=0 performs normal accesses.

Optional Feature:
- Macro: DPRAM_COLLISION_FLAG_EN.
- When defined, the block adds an output collision (1 bit, registered, reset 0).
  - collision is set to 1 for one cycle after any edge where both ports are enabled, the addresses are equal, and at least one port writes.
  - Otherwise collision is 0.
- When not defined, the port does not exist and no detection logic is built.
- Data behaviour is identical either way.

Decomposition:
- Package dpram_pkg holds:
  - constants DATA_WIDTH, ADDR_WIDTH, DEPTH;
  - typedefs addr_t (logic [ADDR_WIDTH-1:0]) and data_t (logic [DATA_WIDTH-1:0]);
  - a port transaction struct {en, we, addr, din}, shared with the dpram_if interface and the testbench.
- dpram_if carries clk as an interface port, the signal set above, and driver/monitor modports.
- Optional sub-module dpram_collision_detect, instantiated only under DPRAM_COLLISION_FLAG_EN. Storage and both port processes stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> both data_out stay 0x00, including asynchronous clear mid-cycle.
- Basic write/read:
  - port A writes 0xA5 at address 0x10;
  - the next cycle port B reads 0x10 -> data_out_port_b=0xA5 one edge later;
  - port A reads 0x10 -> 0xA5.
- Independent parallel access in the same cycle: A writes 0x3C at 0x01 while B writes 0xC3 at 0xFE -> reading back gives A(0xFE)=0xC3 and B(0x01)=0x3C.
- Read-during-write: mem[0x20]=0x11; A writes 0x22 to 0x20 while B reads 0x20 -> B gets 0x11; the next B read gives 0x22.
- Write-write collision at address 0x30: A=0x55 and B=0xAA in the same cycle -> readback 0x55. With DPRAM_COLLISION_FLAG_EN, collision=1 for exactly one cycle.
- Boundaries and hold:
  - write and read addresses 0x00 and 0xFF with 0x00 and 0xFF data -> exact readback;
  - enable=0 for 5 cycles -> data_out unchanged.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants, types and port transaction record for the packet-buffer dual-port RAM.
package dpram_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    logic  en;
    logic  we;
    addr_t addr;
    data_t din;
  } port_txn_t;

  // Same-address access on both ports with at least one writer.
  function automatic logic is_collision(input port_txn_t a, input port_txn_t b);
    return a.en && b.en && (a.addr == b.addr) && (a.we || b.we);
  endfunction

endpackage

// File: rtl/dpram_if.sv
// Signal bundle for dual_port_ram with driver/monitor views.
// Carries the collision flag only when DPRAM_COLLISION_FLAG_EN is defined.
interface dpram_if (
  input logic clk
);
  import dpram_pkg::*;

  logic  rst;
  logic  enable_port_a;
  logic  write_port_a;
  addr_t address_port_a;
  data_t data_in_port_a;
  data_t data_out_port_a;
  logic  enable_port_b;
  logic  write_port_b;
  addr_t address_port_b;
  data_t data_in_port_b;
  data_t data_out_port_b;
`ifdef DPRAM_COLLISION_FLAG_EN
  logic  collision;
`endif

  modport driver (
    input  clk,
    output rst,
    output enable_port_a, write_port_a, address_port_a, data_in_port_a,
    output enable_port_b, write_port_b, address_port_b, data_in_port_b,
`ifdef DPRAM_COLLISION_FLAG_EN
    input  collision,
`endif
    input  data_out_port_a, data_out_port_b
  );

  modport monitor (
    input clk, rst,
    input enable_port_a, write_port_a, address_port_a, data_in_port_a,
    input enable_port_b, write_port_b, address_port_b, data_in_port_b,
`ifdef DPRAM_COLLISION_FLAG_EN
    input collision,
`endif
    input data_out_port_a, data_out_port_b
  );

endinterface

// File: rtl/dpram_collision_detect.sv
// Registered flag for same-address dual-port access with at least one write.
// Built only when DPRAM_COLLISION_FLAG_EN is defined.
module dpram_collision_detect #(
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_a_i,
  input  logic                 we_a_i,
  input  logic [AddrWidth-1:0] addr_a_i,
  input  logic                 en_b_i,
  input  logic                 we_b_i,
  input  logic [AddrWidth-1:0] addr_b_i,
  output logic                 collision_o
);

  logic collision_d, collision_q;

  always_comb begin
    collision_d = en_a_i && en_b_i && (addr_a_i == addr_b_i) && (we_a_i || we_b_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  assign collision_o = collision_q;

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM, read-first on cross-port access, port A wins write-write.
// Optional collision output enabled by DPRAM_COLLISION_FLAG_EN.
module dual_port_ram #(
  parameter int unsigned DATA_WIDTH = dpram_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = dpram_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_port_a,
  input  logic                  write_port_a,
  input  logic [ADDR_WIDTH-1:0] address_port_a,
  input  logic [DATA_WIDTH-1:0] data_in_port_a,
  output logic [DATA_WIDTH-1:0] data_out_port_a,
  input  logic                  enable_port_b,
  input  logic                  write_port_b,
  input  logic [ADDR_WIDTH-1:0] address_port_b,
  input  logic [DATA_WIDTH-1:0] data_in_port_b,
  output logic [DATA_WIDTH-1:0] data_out_port_b
`ifdef DPRAM_COLLISION_FLAG_EN
  ,
  output logic                  collision
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  we_a, we_b, re_a, re_b;
  logic [DATA_WIDTH-1:0] data_out_a_d, data_out_a_q;
  logic [DATA_WIDTH-1:0] data_out_b_d, data_out_b_q;

  always_comb begin
    we_a = enable_port_a && write_port_a && !rst;
    we_b = enable_port_b && write_port_b && !rst;
    re_a = enable_port_a && !write_port_a;
    re_b = enable_port_b && !write_port_b;
    // Array is read before this edge's writes land, giving read-first behaviour.
    data_out_a_d = re_a ? mem_q[address_port_a] : data_out_a_q;
    data_out_b_d = re_b ? mem_q[address_port_b] : data_out_b_q;
  end

  // Port A is written last so it wins a same-address write-write.
  always_ff @(posedge clk) begin
    if (we_b) begin
      mem_q[address_port_b] <= data_in_port_b;
    end
    if (we_a) begin
      mem_q[address_port_a] <= data_in_port_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_a_q <= '0;
      data_out_b_q <= '0;
    end else begin
      data_out_a_q <= data_out_a_d;
      data_out_b_q <= data_out_b_d;
    end
  end

  assign data_out_port_a = data_out_a_q;
  assign data_out_port_b = data_out_b_q;

`ifdef DPRAM_COLLISION_FLAG_EN
  dpram_collision_detect #(
    .AddrWidth (ADDR_WIDTH)
  ) u_collision_detect (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_a_i      (enable_port_a),
    .we_a_i      (write_port_a),
    .addr_a_i    (address_port_a),
    .en_b_i      (enable_port_b),
    .we_b_i      (write_port_b),
    .addr_b_i    (address_port_b),
    .collision_o (collision)
  );
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: a reference model pushes expected outputs per cycle.
module tb_dual_port_ram;
  import dpram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  dpram_if u_if (.clk(clk));

  dual_port_ram u_dut (
    .clk             (clk),
    .rst             (u_if.rst),
    .enable_port_a   (u_if.enable_port_a),
    .write_port_a    (u_if.write_port_a),
    .address_port_a  (u_if.address_port_a),
    .data_in_port_a  (u_if.data_in_port_a),
    .data_out_port_a (u_if.data_out_port_a),
    .enable_port_b   (u_if.enable_port_b),
    .write_port_b    (u_if.write_port_b),
    .address_port_b  (u_if.address_port_b),
    .data_in_port_b  (u_if.data_in_port_b),
    .data_out_port_b (u_if.data_out_port_b)
`ifdef DPRAM_COLLISION_FLAG_EN
    ,
    .collision       (u_if.collision)
`endif
  );

  int total = 0;
  int bad   = 0;

  data_t mem_m [DEPTH];
  data_t out_a_m, out_b_m;
  logic  coll_m;
  data_t qa [$];
  data_t qb [$];
  logic  qc [$];

  task automatic check(input string tag, input data_t got, input data_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic port_txn_t txn(input logic en, input logic we, input addr_t a, input data_t d);
    port_txn_t t;
    t.en   = en;
    t.we   = we;
    t.addr = a;
    t.din  = d;
    return t;
  endfunction

  function automatic port_txn_t wr(input addr_t a, input data_t d);
    return txn(1'b1, 1'b1, a, d);
  endfunction

  function automatic port_txn_t rd(input addr_t a);
    return txn(1'b1, 1'b0, a, data_t'($urandom));
  endfunction

  function automatic port_txn_t idle();
    return txn(1'b0, 1'($urandom), addr_t'($urandom), data_t'($urandom));
  endfunction

  // Drive one cycle, update the model, then compare after the edge.
  task automatic step(input port_txn_t ta, input port_txn_t tb_, input string tag);
    u_if.enable_port_a  = ta.en;
    u_if.write_port_a   = ta.we;
    u_if.address_port_a = ta.addr;
    u_if.data_in_port_a = ta.din;
    u_if.enable_port_b  = tb_.en;
    u_if.write_port_b   = tb_.we;
    u_if.address_port_b = tb_.addr;
    u_if.data_in_port_b = tb_.din;
    if (u_if.rst) begin
      out_a_m = '0;
      out_b_m = '0;
      coll_m  = 1'b0;
    end else begin
      if (ta.en && !ta.we) out_a_m = mem_m[ta.addr];
      if (tb_.en && !tb_.we) out_b_m = mem_m[tb_.addr];
      if (tb_.en && tb_.we) mem_m[tb_.addr] = tb_.din;
      if (ta.en && ta.we) mem_m[ta.addr] = ta.din;
      coll_m = ta.en && tb_.en && (ta.addr == tb_.addr) && (ta.we || tb_.we);
    end
    qa.push_back(out_a_m);
    qb.push_back(out_b_m);
    qc.push_back(coll_m);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_a"}, u_if.data_out_port_a, qa.pop_front());
    check({tag, "_b"}, u_if.data_out_port_b, qb.pop_front());
`ifdef DPRAM_COLLISION_FLAG_EN
    check({tag, "_coll"}, data_t'(u_if.collision), data_t'(qc.pop_front()));
`else
    void'(qc.pop_front());
`endif
  endtask

  function automatic port_txn_t rand_txn();
    return txn(1'($urandom), 1'($urandom), addr_t'($urandom_range(0, 15)), data_t'($urandom));
  endfunction

  initial begin
    out_a_m = '0;
    out_b_m = '0;
    coll_m  = 1'b0;
    u_if.rst = 1'b1;
    step(rand_txn(), rand_txn(), "rst0");
    step(rand_txn(), rand_txn(), "rst1");
    u_if.rst = 1'b0;

    step(wr(8'h10, 8'hA5), idle(), "wr10");
    step(idle(), rd(8'h10), "rdb10");
    step(rd(8'h10), idle(), "rda10");

    step(wr(8'h01, 8'h3C), wr(8'hFE, 8'hC3), "par_wr");
    step(rd(8'hFE), rd(8'h01), "par_rd");

    step(wr(8'h20, 8'h11), idle(), "rdw_init");
    step(wr(8'h20, 8'h22), rd(8'h20), "rdw_old");
    step(idle(), rd(8'h20), "rdw_new");

    step(wr(8'h30, 8'h55), wr(8'h30, 8'hAA), "ww_coll");
    step(rd(8'h30), rd(8'h30), "ww_read");
    step(idle(), idle(), "coll_clr");

    step(wr(8'h00, 8'hFF), wr(8'hFF, 8'h00), "bnd_wr0");
    step(rd(8'hFF), rd(8'h00), "bnd_rd0");
    step(wr(8'h00, 8'h00), wr(8'hFF, 8'hFF), "bnd_wr1");
    step(rd(8'h00), rd(8'hFF), "bnd_rd1");

    step(rd(8'h10), rd(8'h01), "pre_hold");
    for (int i = 0; i < 5; i++) step(idle(), idle(), "hold");

    // Asynchronous clear in the middle of a cycle, with writes presented during reset.
    #2 u_if.rst = 1'b1;
    #1;
    check("async_a", u_if.data_out_port_a, 8'h00);
    check("async_b", u_if.data_out_port_b, 8'h00);
    step(wr(8'h10, 8'h77), wr(8'h01, 8'h88), "rst_wr");
    step(rand_txn(), rand_txn(), "rst_rand");
    u_if.rst = 1'b0;
    step(rd(8'h10), rd(8'h01), "post_rst");

    for (int i = 0; i < 16; i++) step(wr(addr_t'(i), data_t'($urandom)), idle(), "fill");
    for (int i = 0; i < 150; i++) step(rand_txn(), rand_txn(), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
